// File: rtl/vga_sync_gen_pkg.sv
//------------------------------------------------------------------------------
// Module      : vga_pkg
// Description : Default 640x480@60 Hz timing constants, derived totals,
//               count typedefs and sync-level helper for vga_sync_gen.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  // 640x480@60 Hz, 25 MHz pixel rate
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_XW = $clog2(VGA_H_TOTAL);
  localparam int VGA_YW = $clog2(VGA_V_TOTAL);

  // Asserted sync level: 0 means the sync pulses are active-low
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef logic [VGA_XW-1:0] hcount_t;
  typedef logic [VGA_YW-1:0] vcount_t;

  // Map an "in sync window" flag onto the pin level for a given polarity
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
//------------------------------------------------------------------------------
// Module      : vga_sync_gen_if
// Description : Pixel strobe in, sync/video/coordinate bundle out.
//               master = timing generator, slave = pixel/colour consumer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_sync_gen_if
  import vga_pkg::*;
#(
  parameter int XW = VGA_XW,
  parameter int YW = VGA_YW
) ();

  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, video_on, x, y, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, x, y, frame_start
  );

endinterface

`default_nettype wire

// File: rtl/vga_sync_gen_axis_counter.sv
//------------------------------------------------------------------------------
// Module      : vga_axis_counter
// Description : One timing axis (horizontal or vertical). Wrapping counter
//               that resets to its last value, plus decodes of the next
//               count so the parent can register them alongside the count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
  parameter int SYNC_END   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC - 1,
  parameter int ACTIVE_LEN = VGA_H_ACTIVE,
  parameter int W          = $clog2(TOTAL)
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,    // current count is the last position
  output logic         active,  // next count lies in the active region
  output logic         sync     // next count lies in the sync window
);

  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_LIMIT = W'(ACTIVE_LEN);
  localparam logic [W-1:0] SYNC_LO   = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI   = W'(SYNC_END);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap = (count_q == LAST);

  // Next count: step on inc, wrapping from LAST back to zero
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Count register; reset parks on LAST so the first step lands on zero
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (count_d < ACT_LIMIT);
  assign sync   = (count_d >= SYNC_LO) && (count_d <= SYNC_HI);

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
//------------------------------------------------------------------------------
// Module      : vga_sync_gen
// Description : VGA horizontal/vertical timing generator advancing one pixel
//               per pix_en strobe. All outputs registered; sync/video decodes
//               are taken from the next count so they line up with x/y.
//               Optional macro VGA_SYNC_DELAY_EN: hsync/vsync/video_on pass
//               through one extra pix_en-qualified stage (one pixel behind
//               x/y); frame_start is never delayed.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic           clk_in,
  input  logic           rst_n,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic [XW-1:0] h_count;
  logic          h_wrap;
  logic          h_active;
  logic          h_sync;
  logic [YW-1:0] v_count;
  logic          v_wrap;
  logic          v_active;
  logic          v_sync;
  logic          v_inc;
  logic          frame_start_d;

  // A line ends when the horizontal axis wraps on a strobe
  assign v_inc = bus.pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC - 1),
    .ACTIVE_LEN (H_ACTIVE),
    .W          (XW)
  ) u_hcnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (bus.pix_en),
    .count  (h_count),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC - 1),
    .ACTIVE_LEN (V_ACTIVE),
    .W          (YW)
  ) u_vcnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (v_inc),
    .count  (v_count),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  // Entering (0,0) happens only on the strobe that wraps both axes
  assign frame_start_d = bus.pix_en & h_wrap & v_wrap;

  logic hsync_q;
  logic vsync_q;
  logic video_on_q;
  logic frame_start_q;

  // Output registers, loaded from decodes of the next count
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= sync_level(h_sync, SYNC_POL);
      vsync_q       <= sync_level(v_sync, SYNC_POL);
      video_on_q    <= h_active & v_active;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q;
  logic vsync_dly_q;
  logic video_on_dly_q;

  // One-pixel delay stage so syncs line up with a registered colour lookup
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_dly_q    <= ~SYNC_POL;
      vsync_dly_q    <= ~SYNC_POL;
      video_on_dly_q <= 1'b0;
    end else if (bus.pix_en) begin
      hsync_dly_q    <= hsync_q;
      vsync_dly_q    <= vsync_q;
      video_on_dly_q <= video_on_q;
    end
  end

  assign bus.hsync    = hsync_dly_q;
  assign bus.vsync    = vsync_dly_q;
  assign bus.video_on = video_on_dly_q;
`else
  assign bus.hsync    = hsync_q;
  assign bus.vsync    = vsync_q;
  assign bus.video_on = video_on_q;
`endif

  assign bus.x           = h_count;
  assign bus.y           = v_count;
  assign bus.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen. Two instances: default
//               640x480 timing, and a miniature active-high-sync timing that
//               allows whole frames and mid-vsync reset in few cycles.
//               Reference model tracks a linear pixel index per frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int NI = 2;
  localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HB = 3;
  localparam int B_VA = 6, B_VFP = 1, B_VS = 2, B_VB = 1;
  localparam logic B_POL = 1'b1;

  localparam int HA  [NI] = '{640, B_HA};
  localparam int HFP [NI] = '{16,  B_HFP};
  localparam int HS  [NI] = '{96,  B_HS};
  localparam int HB  [NI] = '{48,  B_HB};
  localparam int VA  [NI] = '{480, B_VA};
  localparam int VFP [NI] = '{10,  B_VFP};
  localparam int VS  [NI] = '{2,   B_VS};
  localparam int VB  [NI] = '{33,  B_VB};
  localparam bit POL [NI] = '{1'b0, B_POL};

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pix_en = 1'b0;

  vga_sync_gen_if bus_a ();
  vga_sync_gen_if #(.XW(4), .YW(4)) bus_b ();

  assign bus_a.pix_en = pix_en;
  assign bus_b.pix_en = pix_en;

  vga_sync_gen dut_a (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus_a)
  );

  vga_sync_gen #(
    .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HB),
    .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VB),
    .SYNC_POL (B_POL)
  ) dut_b (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus_b)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: linear pixel index within the frame, delayed levels
  int p   [NI];
  bit dh  [NI];
  bit dv  [NI];
  bit dvo [NI];
  bit fs  [NI];

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int ht(input int i);
    return HA[i] + HFP[i] + HS[i] + HB[i];
  endfunction

  function automatic int vt(input int i);
    return VA[i] + VFP[i] + VS[i] + VB[i];
  endfunction

  function automatic int lvl(input bit asserted, input bit pol);
    return asserted ? int'(pol) : int'(!pol);
  endfunction

  function automatic void decode(input int i, input int pos, output int ex, output int ey,
                                 output bit vo, output bit hsa, output bit vsa);
    ex  = pos % ht(i);
    ey  = pos / ht(i);
    vo  = (ex < HA[i]) && (ey < VA[i]);
    hsa = (ex >= HA[i] + HFP[i]) && (ex < HA[i] + HFP[i] + HS[i]);
    vsa = (ey >= VA[i] + VFP[i]) && (ey < VA[i] + VFP[i] + VS[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      p[i]   = ht(i) * vt(i) - 1;
      dh[i]  = 1'b0;
      dv[i]  = 1'b0;
      dvo[i] = 1'b0;
      fs[i]  = 1'b0;
    end
  endtask

  task automatic model_advance(input bit strobe);
    int ex, ey;
    bit vo, hsa, vsa;
    for (int i = 0; i < NI; i++) begin
      if (strobe) begin
        decode(i, p[i], ex, ey, vo, hsa, vsa);
        dh[i]  = hsa;
        dv[i]  = vsa;
        dvo[i] = vo;
        p[i]   = (p[i] + 1) % (ht(i) * vt(i));
        fs[i]  = (p[i] == 0);
      end else begin
        fs[i]  = 1'b0;
      end
    end
  endtask

  task automatic expect_out(input int i, output int ex, output int ey,
                            output int evo, output int ehs, output int evs);
    bit vo, hsa, vsa;
    decode(i, p[i], ex, ey, vo, hsa, vsa);
`ifdef VGA_SYNC_DELAY_EN
    evo = int'(dvo[i]);
    ehs = lvl(dh[i], POL[i]);
    evs = lvl(dv[i], POL[i]);
`else
    evo = int'(vo);
    ehs = lvl(hsa, POL[i]);
    evs = lvl(vsa, POL[i]);
`endif
  endtask

  task automatic check_all();
    int ex, ey, evo, ehs, evs;
    expect_out(0, ex, ey, evo, ehs, evs);
    check("a_x",           int'(bus_a.x),           ex);
    check("a_y",           int'(bus_a.y),           ey);
    check("a_video_on",    int'(bus_a.video_on),    evo);
    check("a_hsync",       int'(bus_a.hsync),       ehs);
    check("a_vsync",       int'(bus_a.vsync),       evs);
    check("a_frame_start", int'(bus_a.frame_start), int'(fs[0]));
    expect_out(1, ex, ey, evo, ehs, evs);
    check("b_x",           int'(bus_b.x),           ex);
    check("b_y",           int'(bus_b.y),           ey);
    check("b_video_on",    int'(bus_b.video_on),    evo);
    check("b_hsync",       int'(bus_b.hsync),       ehs);
    check("b_vsync",       int'(bus_b.vsync),       evs);
    check("b_frame_start", int'(bus_b.frame_start), int'(fs[1]));
  endtask

  // Drive pix_en for one clock, then sample on the falling edge
  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    @(negedge clk);
    model_advance(en && (rst_n == 1'b1));
    check_all();
  endtask

  // Random strobes until instance i reaches linear position target
  task automatic run_to(input int i, input int target);
    int guard = 0;
    while (p[i] != target && guard < 20000) begin
      step($urandom_range(0, 3) != 0);
      guard++;
    end
  endtask

  int cnt_vo, cnt_vs, cnt_fs;
`ifdef VGA_SYNC_DELAY_EN
  localparam int HS_AT_656 = 1;
  localparam int HS_AT_752 = 0;
`else
  localparam int HS_AT_656 = 0;
  localparam int HS_AT_752 = 1;
`endif

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    step(1'b1);                       // strobe while in reset: no motion
    check("a_rst_x", int'(bus_a.x), 799);
    check("a_rst_y", int'(bus_a.y), 524);

    rst_n = 1'b1;
    step(1'b1);                       // (799,524) -> (0,0)
    check("a_first_x",  int'(bus_a.x), 0);
    check("a_first_y",  int'(bus_a.y), 0);
    check("a_first_fs", int'(bus_a.frame_start), 1);
    step(1'b0);
    check("a_fs_hold", int'(bus_a.frame_start), 0);

    run_to(0, 656);
    check("a_x_656",     int'(bus_a.x), 656);
    check("a_hsync_656", int'(bus_a.hsync), HS_AT_656);
    step(1'b1);
    check("a_hsync_657", int'(bus_a.hsync), 0);
    run_to(0, 752);
    check("a_hsync_752", int'(bus_a.hsync), HS_AT_752);
    step(1'b1);
    check("a_hsync_753", int'(bus_a.hsync), 1);
    run_to(0, 800);
    check("a_line_x", int'(bus_a.x), 0);
    check("a_line_y", int'(bus_a.y), 1);

    run_to(0, 1100);
    repeat (100) step(1'b0);
    check("a_hold_x", int'(bus_a.x), 300);
    check("a_hold_y", int'(bus_a.y), 1);

    // Whole miniature frame with continuous strobes
    run_to(1, 0);
    cnt_vo = 0; cnt_vs = 0; cnt_fs = 0;
    repeat (ht(1) * vt(1)) begin
      step(1'b1);
      cnt_vo += int'(bus_b.video_on);
      cnt_vs += int'(bus_b.vsync == B_POL);
      cnt_fs += int'(bus_b.frame_start);
    end
    check("b_frame_video_on", cnt_vo, B_HA * B_VA);
    check("b_frame_vsync",    cnt_vs, B_VS * ht(1));
    check("b_frame_fs",       cnt_fs, 1);

    // Reset mid-vsync, just past the hsync window
    run_to(1, (B_VA + B_VFP) * ht(1) + (B_HA + B_HFP + B_HS));
    check("b_vsync_pre_rst", int'(bus_b.vsync), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("b_rst_x",     int'(bus_b.x), ht(1) - 1);
    check("b_rst_y",     int'(bus_b.y), vt(1) - 1);
    check("b_rst_vsync", int'(bus_b.vsync), 0);
    check("a_rst2_hsync", int'(bus_a.hsync), 1);
    check("a_rst2_vsync", int'(bus_a.vsync), 1);
    @(negedge clk);
    step(1'b1);
    rst_n = 1'b1;
    repeat (600) step($urandom_range(0, 1) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
